load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Multi-cycle load/store engine directly downstream of the CPU datapath's ALU, which produces the effective address; it replaces the combinational data-memory path.
- Accepts one load or store request from the core and stalls the core until complete.
- Generates word-aligned addresses, byte enables and replicated store data toward a valid/ready data memory.
- Returns sign- or zero-extended load data for the register writeback mux.

Parameters:
- TIMEOUT, 255: cycles to wait for mem_ready before aborting with err.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset; driven from start (start=0 holds the block in reset).
- lsu_req  in  1  core request valid; held stable while stall=1.
- lsu_we  in  1  1=store (sb/sh/sw), 0=load.
- funct3  in  3  instruction[14:12]; size/sign select.
- addr  in  ADDR_W  effective address from the ALU.
- wdata  in  32  store data (rs2).
- rdata  out  32  extended load result; valid when done=1.
- stall  out  1  combinational: lsu_req & ~done; freezes PC and regWrite.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse with done on misalign, illegal funct3 or timeout.
- mem_req  out  1  memory request valid.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  {addr[ADDR_W-1:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  memory read word.
- mem_ready  in  1  memory accepts a write or returns read data this cycle.

Behaviour:
- Reset: state IDLE; mem_req, mem_we, done and err = 0; rdata, mem_addr, mem_be, mem_wdata and the timeout counter = 0. Reset is asynchronous and may assert in any state; it drops any in-flight request without a done pulse.
- FSM: IDLE, ACCESS, RESP.
- IDLE:
  - If lsu_req and the request is legal: register mem_addr, mem_be, mem_we and mem_wdata, then go to ACCESS.
  - If lsu_req and the request is illegal: go to RESP with err=1; no memory access.
- ACCESS:
  - mem_req=1 with all mem_* signals stable.
  - On mem_ready: capture the extracted load data into rdata (loads only), go to RESP.
  - Counter increments each cycle without mem_ready. On reaching TIMEOUT: drop mem_req, go to RESP with err=1, rdata=0.
- RESP: done=1 for exactly one cycle, then go to IDLE. A new lsu_req is not sampled until IDLE, so back-to-back accesses take a minimum of 3 cycles each.
- Latency:
  - lsu_req sampled at cycle 0; mem_req asserted in cycle 1.
  - If mem_ready arrives in cycle k (k≥1), done is asserted in cycle k+1.
  - Zero-wait memory gives done at cycle 2.
- Legality:
  - funct3 011, 110 and 111 are illegal.
  - Stores with funct3 100 or 101 are illegal.
  - Half accesses with addr[0]≠0 are misaligned.
  - Word accesses with addr[1:0]≠0 are misaligned.
- Byte enables:
  - byte: 4'b0001<<addr[1:0].
  - half: 4'b0011<<addr[1:0].
  - word: 4'b1111.
- Store data: byte replicates {4{wdata[7:0]}}; half replicates {2{wdata[15:0]}}; word passes wdata.
- Load data:
  - sh = mem_rdata >> (8*addr[1:0]).
  - lb sign-extends sh[7:0]; lbu zero-extends sh[7:0].
  - lh sign-extends sh[15:0]; lhu zero-extends sh[15:0].
  - lw passes the word.
- rdata holds its value until the next load completes; stores leave it unchanged.
- Core deassertion: if lsu_req drops while in ACCESS, the access still completes (memory transactions are never abandoned).

Decomposition:
- Shared package lsu_pkg:
  - funct3 encodings: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - FSM state enum.
  - Byte-enable width constant.
- One combinational sub-module, lsu_align, is natural: it takes funct3, addr[1:0], wdata and mem_rdata and produces mem_be, mem_wdata, extracted load data and a legal flag. The FSM and timeout counter stay in load_store_unit.

Test Plan:
- lw, addr=0x104, mem_rdata=0xDEADBEEF, mem_ready in cycle 1 -> mem_addr=0x104, mem_be=1111, done in cycle 2, rdata=0xDEADBEEF, err=0.
- lb, addr=0x103, mem_rdata=0x80FF0011 -> mem_be=1000, rdata=0xFFFFFF80; same stimulus with lbu -> rdata=0x00000080.
- sh, addr=0x206, wdata=0x1234ABCD -> mem_addr=0x204, mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1; mem_ready delayed 5 cycles -> stall=1 throughout, done in cycle 7.
- lw, addr=0x102 -> no mem_req at any cycle, done and err in cycle 1 (RESP), stall low afterwards.
- TIMEOUT=4, mem_ready held 0 -> mem_req high for 4 cycles, then done and err together, rdata=0.
- rst asserted mid-ACCESS -> mem_req=0 immediately (asynchronous), state IDLE, no done pulse; the next lw after reset release completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// ============================================================================
// Module : lsu_pkg
// Shared funct3 encodings, FSM state type and lane constants for the LSU.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int BE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } lsu_state_e;

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module : lsu_align
// Lane steering: byte enables, store replication, load extraction, legality.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      off_i,
    input  logic            we_i,
    input  logic [31:0]     wdata_i,
    input  logic [31:0]     rdata_i,
    output logic [BE_W-1:0] be_o,
    output logic [31:0]     wdata_o,
    output logic [31:0]     load_o,
    output logic            legal_o
);

    logic [31:0] w_shifted;

    // The addressed lane is moved down to bit 0 before extension.
    assign w_shifted = rdata_i >> {off_i, 3'b000};

    always_comb begin
        be_o    = '0;
        wdata_o = wdata_i;
        load_o  = w_shifted;
        legal_o = 1'b0;
        case (funct3_i)
            F3_B: begin
                legal_o = 1'b1;
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
                load_o  = {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            F3_BU: begin
                legal_o = ~we_i;
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
                load_o  = {24'h0, w_shifted[7:0]};
            end
            F3_H: begin
                legal_o = ~off_i[0];
                be_o    = 4'b0011 << off_i;
                wdata_o = {2{wdata_i[15:0]}};
                load_o  = {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            F3_HU: begin
                legal_o = ~we_i & ~off_i[0];
                be_o    = 4'b0011 << off_i;
                wdata_o = {2{wdata_i[15:0]}};
                load_o  = {16'h0, w_shifted[15:0]};
            end
            F3_W: begin
                legal_o = (off_i == 2'b00);
                be_o    = 4'b1111;
                wdata_o = wdata_i;
            end
            default: begin
                legal_o = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module : load_store_unit
// Multi-cycle load/store engine between the core and a valid/ready memory.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_req,
    input  logic              lsu_we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              done,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BE_W-1:0]   mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e        state_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       rdata_q;
    logic              done_q;
    logic              err_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [BE_W-1:0]   mem_be_q;
    logic [31:0]       mem_wdata_q;

    logic [2:0]        w_f3;
    logic [1:0]        w_off;
    logic [BE_W-1:0]   w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_load;
    logic              w_legal;

    // Live request decoded while idle; the captured copy drives extraction so
    // the core may drop or change its request during the access.
    assign w_f3  = (state_q == S_IDLE) ? funct3    : f3_q;
    assign w_off = (state_q == S_IDLE) ? addr[1:0] : off_q;

    lsu_align u_align (
        .funct3_i (w_f3),
        .off_i    (w_off),
        .we_i     (lsu_we),
        .wdata_i  (wdata),
        .rdata_i  (mem_rdata),
        .be_o     (w_be),
        .wdata_o  (w_wdata),
        .load_o   (w_load),
        .legal_o  (w_legal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
            cnt_q       <= '0;
            rdata_q     <= 32'h0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= 32'h0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (lsu_req) begin
                        f3_q  <= funct3;
                        off_q <= addr[1:0];
                        if (w_legal) begin
                            mem_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                            mem_be_q    <= w_be;
                            mem_we_q    <= lsu_we;
                            mem_wdata_q <= w_wdata;
                            mem_req_q   <= 1'b1;
                            cnt_q       <= '0;
                            state_q     <= S_ACCESS;
                        end else begin
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= S_RESP;
                        end
                    end
                end
                S_ACCESS: begin
                    if (mem_ready) begin
                        if (!mem_we_q) begin
                            rdata_q <= w_load;
                        end
                        mem_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        mem_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        err_q     <= 1'b1;
                        rdata_q   <= 32'h0;
                        state_q   <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rdata     = rdata_q;
    assign done      = done_q;
    assign err       = err_q;
    assign stall     = lsu_req & ~done_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module : tb_load_store_unit
// Vector table, directed corner sequences and random ops against a rule model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_req, lsu_we, mem_ready;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, mem_rdata;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic        stall, done, err, mem_req, mem_we;
    logic [3:0]  mem_be;

    logic        lsu_req2, lsu_we2, mem_ready2;
    logic [2:0]  funct3_2;
    logic [31:0] addr2, wdata2, mem_rdata2;
    logic [31:0] rdata2, mem_addr2, mem_wdata2;
    logic        stall2, done2, err2, mem_req2, mem_we2;
    logic [3:0]  mem_be2;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] model_rd;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(16), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .lsu_req(lsu_req), .lsu_we(lsu_we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .done(done),
        .err(err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    load_store_unit #(.TIMEOUT(4), .ADDR_W(32)) dut_to (
        .clk(clk), .rst(rst), .lsu_req(lsu_req2), .lsu_we(lsu_we2), .funct3(funct3_2),
        .addr(addr2), .wdata(wdata2), .rdata(rdata2), .stall(stall2), .done(done2),
        .err(err2), .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2),
        .mem_be(mem_be2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2),
        .mem_ready(mem_ready2)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        int          delay;
        logic        exp_err;
        logic [3:0]  exp_be;
        logic [31:0] exp_mwd;
        logic [31:0] exp_rd;
        int          exp_done;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    // Rule-level reference: sizes and lanes derived with plain arithmetic.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] mr,
                                  output logic legal, output logic [3:0] be,
                                  output logic [31:0] mwd, output logic [31:0] ld);
        int nb, off;
        logic [31:0] mask, v;
        nb    = 1 << f3[1:0];
        off   = int'(a[1:0]);
        legal = !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) && !(we && f3[2]) && (off % nb == 0);
        be    = 4'(((1 << nb) - 1) << off);
        if (nb == 1)      mwd = {24'h0, wd[7:0]} * 32'h01010101;
        else if (nb == 2) mwd = {16'h0, wd[15:0]} * 32'h00010001;
        else              mwd = wd;
        mask = (nb >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
        v    = (mr >> (8 * off)) & mask;
        if (!f3[2] && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
        ld = v;
    endfunction

    // One core request; memory answers delay cycles after mem_req first rises.
    // drop >= 0 withdraws and scrambles the core request in that cycle.
    task automatic check_op(input int idx, input logic we, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mr,
                            input int delay, input int drop, input logic exp_err,
                            input logic [3:0] exp_be, input logic [31:0] exp_mwd,
                            input logic [31:0] exp_rd, input int exp_done);
        int cyc, done_cyc, nreq;
        logic seen, unstable, stall_bad, err_o, mwe_o;
        logic [31:0] rd_o, maddr_o, mwd_o;
        logic [3:0]  be_o;
        cyc = 0; done_cyc = -1; nreq = 0; seen = 0; unstable = 0; stall_bad = 0;
        err_o = 0; mwe_o = 0; rd_o = 0; maddr_o = 0; mwd_o = 0; be_o = 0;
        @(posedge clk); #1;
        lsu_req = 1'b1; lsu_we = we; funct3 = f3; addr = a; wdata = wd; mem_rdata = mr;
        mem_ready = 1'b0;
        while (done_cyc < 0 && cyc <= 40) begin
            if (cyc == drop) begin
                lsu_req = 1'b0; funct3 = 3'b111; addr = 32'hFFFF_FFFF;
            end
            if (mem_req) begin
                nreq++;
                if (!seen) begin
                    maddr_o = mem_addr; be_o = mem_be; mwd_o = mem_wdata; mwe_o = mem_we;
                end else if (mem_addr !== maddr_o || mem_be !== be_o || mem_wdata !== mwd_o || mem_we !== mwe_o) begin
                    unstable = 1'b1;
                end
                seen = 1'b1;
                mem_ready = (cyc >= 1 + delay);
            end else begin
                mem_ready = 1'b0;
            end
            @(negedge clk);
            if (lsu_req && stall !== (cyc != exp_done)) stall_bad = 1'b1;
            if (done) begin
                done_cyc = cyc; err_o = err; rd_o = rdata;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        lsu_req = 1'b0; mem_ready = 1'b0;
        chk("done_cycle", idx, done_cyc, exp_done);
        chk("err", idx, {31'h0, err_o}, {31'h0, exp_err});
        chk("mem_req_cycles", idx, nreq, exp_err ? 0 : exp_done - 1);
        chk("rdata", idx, rd_o, exp_rd);
        chk("stall", idx, {31'h0, stall_bad}, 32'h0);
        if (!exp_err) begin
            chk("mem_addr", idx, maddr_o, {a[31:2], 2'b00});
            chk("mem_be", idx, {28'h0, be_o}, {28'h0, exp_be});
            chk("mem_we", idx, {31'h0, mwe_o}, {31'h0, we});
            chk("mem_stable", idx, {31'h0, unstable}, 32'h0);
            if (we) chk("mem_wdata", idx, mwd_o, exp_mwd);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic        r_we, legal;
        logic [2:0]  r_f3;
        logic [31:0] r_a, r_wd, r_mr, e_mwd, e_ld;
        logic [3:0]  e_be;
        int          r_d, dc, nq;
        logic        got, e2;
        logic [31:0] r2;

        rst = 1'b0;
        lsu_req = 0; lsu_we = 0; funct3 = 0; addr = 0; wdata = 0; mem_rdata = 0; mem_ready = 0;
        lsu_req2 = 0; lsu_we2 = 0; funct3_2 = 0; addr2 = 0; wdata2 = 0; mem_rdata2 = 0; mem_ready2 = 0;

        tbl[0]  = '{1'b0, F3_W,  32'h104, 32'h0,        32'hDEADBEEF, 0, 1'b0, 4'hF, 32'h0,        32'hDEADBEEF, 2};
        tbl[1]  = '{1'b0, F3_B,  32'h103, 32'h0,        32'h80FF0011, 0, 1'b0, 4'h8, 32'h0,        32'hFFFFFF80, 2};
        tbl[2]  = '{1'b0, F3_BU, 32'h103, 32'h0,        32'h80FF0011, 0, 1'b0, 4'h8, 32'h0,        32'h00000080, 2};
        tbl[3]  = '{1'b1, F3_H,  32'h206, 32'h1234ABCD, 32'h0,        5, 1'b0, 4'hC, 32'hABCDABCD, 32'h00000080, 7};
        tbl[4]  = '{1'b0, F3_W,  32'h102, 32'h0,        32'h0,        0, 1'b1, 4'h0, 32'h0,        32'h00000080, 1};
        tbl[5]  = '{1'b0, F3_H,  32'h102, 32'h0,        32'h80012345, 1, 1'b0, 4'hC, 32'h0,        32'hFFFF8001, 3};
        tbl[6]  = '{1'b0, F3_HU, 32'h100, 32'h0,        32'h1234F00D, 2, 1'b0, 4'h3, 32'h0,        32'h0000F00D, 4};
        tbl[7]  = '{1'b1, F3_B,  32'h301, 32'h000000A5, 32'h0,        0, 1'b0, 4'h2, 32'hA5A5A5A5, 32'h0000F00D, 2};
        tbl[8]  = '{1'b1, F3_W,  32'h400, 32'hCAFEBABE, 32'h0,        1, 1'b0, 4'hF, 32'hCAFEBABE, 32'h0000F00D, 3};
        tbl[9]  = '{1'b1, F3_BU, 32'h000, 32'h11111111, 32'h0,        0, 1'b1, 4'h0, 32'h0,        32'h0000F00D, 1};
        tbl[10] = '{1'b0, 3'b011, 32'h000, 32'h0,       32'h0,        0, 1'b1, 4'h0, 32'h0,        32'h0000F00D, 1};
        tbl[11] = '{1'b0, F3_H,  32'h101, 32'h0,        32'h0,        0, 1'b1, 4'h0, 32'h0,        32'h0000F00D, 1};
        tbl[12] = '{1'b0, F3_B,  32'h102, 32'h0,        32'h007F0000, 0, 1'b0, 4'h4, 32'h0,        32'h0000007F, 2};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdata", 0, rdata, 32'h0);
        chk("reset_mem_req", 0, {31'h0, mem_req}, 32'h0);
        chk("reset_done", 0, {31'h0, done}, 32'h0);
        chk("reset_err", 0, {31'h0, err}, 32'h0);
        chk("reset_mem_addr", 0, mem_addr, 32'h0);
        chk("reset_mem_be", 0, {28'h0, mem_be}, 32'h0);
        chk("reset_mem_wdata", 0, mem_wdata, 32'h0);
        chk("reset_mem_we", 0, {31'h0, mem_we}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            check_op(i, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].mrdata,
                     tbl[i].delay, -1, tbl[i].exp_err, tbl[i].exp_be, tbl[i].exp_mwd,
                     tbl[i].exp_rd, tbl[i].exp_done);
        end

        // Core withdraws mid-access; the memory transaction must still finish.
        check_op(50, 1'b0, F3_W, 32'h108, 32'h0, 32'h11223344, 3, 2, 1'b0, 4'hF, 32'h0,
                 32'h11223344, 5);

        // Asynchronous reset in the middle of an access.
        @(posedge clk); #1;
        lsu_req = 1'b1; lsu_we = 1'b0; funct3 = F3_W; addr = 32'h10C; mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("rst_pre_mem_req", 51, {31'h0, mem_req}, 32'h1);
        rst = 1'b0;
        #1;
        chk("rst_mem_req", 51, {31'h0, mem_req}, 32'h0);
        chk("rst_mem_addr", 51, mem_addr, 32'h0);
        chk("rst_rdata", 51, rdata, 32'h0);
        lsu_req = 1'b0;
        @(negedge clk);
        chk("rst_done_a", 51, {31'h0, done}, 32'h0);
        @(posedge clk); #1;
        chk("rst_done_b", 51, {31'h0, done}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        check_op(52, 1'b0, F3_W, 32'h10C, 32'h0, 32'h0BADF00D, 1, -1, 1'b0, 4'hF, 32'h0,
                 32'h0BADF00D, 3);
        model_rd = 32'h0BADF00D;

        for (int i = 0; i < 300; i++) begin
            r_we = 1'($urandom_range(0, 1));
            r_f3 = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            r_wd = $urandom;
            r_mr = $urandom;
            r_d  = int'($urandom_range(0, 4));
            model(r_we, r_f3, r_a, r_wd, r_mr, legal, e_be, e_mwd, e_ld);
            if (legal && !r_we) model_rd = e_ld;
            check_op(100 + i, r_we, r_f3, r_a, r_wd, r_mr, r_d, -1, !legal, e_be, e_mwd,
                     model_rd, legal ? 2 + r_d : 1);
        end

        // Timeout on the TIMEOUT=4 instance, after a load leaves rdata non-zero.
        @(posedge clk); #1;
        lsu_req2 = 1'b1; lsu_we2 = 1'b0; funct3_2 = F3_W; addr2 = 32'h0;
        mem_rdata2 = 32'h5A5A5A5A; mem_ready2 = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (done2) got = 1'b1;
        end
        chk("to_warm_done", 200, {31'h0, got}, 32'h1);
        chk("to_warm_rdata", 200, rdata2, 32'h5A5A5A5A);
        lsu_req2 = 1'b0; mem_ready2 = 1'b0;
        @(posedge clk); #1;
        lsu_req2 = 1'b1;
        dc = -1; nq = 0; e2 = 1'b0; r2 = 32'hFFFF_FFFF;
        for (int c = 1; c <= 20 && dc < 0; c++) begin
            @(posedge clk); #1;
            if (mem_req2) nq++;
            @(negedge clk);
            if (done2) begin
                dc = c; e2 = err2; r2 = rdata2;
            end
        end
        lsu_req2 = 1'b0;
        chk("to_mem_req_cycles", 201, nq, 4);
        chk("to_done_cycle", 201, dc, 5);
        chk("to_err", 201, {31'h0, e2}, 32'h1);
        chk("to_rdata", 201, r2, 32'h0);
        chk("to_mem_req_dropped", 201, {31'h0, mem_req2}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
